// File: rtl/sprite_blitter.sv
// Sprite ROM to framebuffer copy engine: scans the sprite in row-major order,
// drops key-coloured and off-screen pixels, and issues one valid/ready write per visible pixel.
module sprite_blitter #(
  parameter int          FB_WIDTH  = 320,
  parameter int          FB_HEIGHT = 240,
  parameter logic [15:0] KEY_COLOR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  pos_x,
  input  logic [7:0]  pos_y,
  output logic        busy,
  output logic        done,
  output logic [16:0] pixel,
  input  logic [8:0]  width,
  input  logic [8:0]  height,
  input  logic [15:0] color,
  output logic [16:0] fb_addr,
  output logic [15:0] fb_data,
  output logic        fb_we,
  input  logic        fb_ready
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCAN,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [9:0]  FB_W10 = 10'(FB_WIDTH);
  localparam logic [9:0]  FB_H10 = 10'(FB_HEIGHT);
  localparam logic [16:0] FB_W17 = 17'(FB_WIDTH);

  state_t      r_state;
  state_t      w_state_next;
  logic [8:0]  r_pos_x;
  logic [7:0]  r_pos_y;
  logic [8:0]  r_width;
  logic [8:0]  r_height;
  logic [8:0]  r_col;
  logic [8:0]  r_row;
  logic [16:0] r_index;
  logic [16:0] r_fb_addr;
  logic [15:0] r_fb_data;

  logic [9:0]  w_sum_x;
  logic [9:0]  w_sum_y;
  logic [16:0] w_fb_addr;
  logic        w_skip;
  logic        w_last;
  logic        w_col_wrap;
  logic        w_advance;
  logic        w_load_fb;

  // Screen coordinates are kept at 10 bits so pos + offset never wraps back on-screen.
  assign w_sum_x    = {1'b0, r_pos_x} + {1'b0, r_col};
  assign w_sum_y    = {2'b00, r_pos_y} + {1'b0, r_row};
  assign w_fb_addr  = {7'd0, w_sum_y} * FB_W17 + {7'd0, w_sum_x};
  assign w_skip     = (color == KEY_COLOR) || (w_sum_x >= FB_W10) || (w_sum_y >= FB_H10);
  assign w_col_wrap = (r_col == r_width - 9'd1);
  assign w_last     = w_col_wrap && (r_row == r_height - 9'd1);

  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    w_load_fb    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_SETUP;
      end
      ST_SETUP: begin
        w_state_next = (r_width == 9'd0 || r_height == 9'd0) ? ST_DONE : ST_SCAN;
      end
      ST_SCAN: begin
        if (w_skip) begin
          w_advance    = 1'b1;
          w_state_next = w_last ? ST_DONE : ST_SCAN;
        end else begin
          w_load_fb    = 1'b1;
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (fb_ready) begin
          w_advance    = 1'b1;
          w_state_next = w_last ? ST_DONE : ST_SCAN;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pos_x   <= '0;
      r_pos_y   <= '0;
      r_width   <= '0;
      r_height  <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_index   <= '0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && start) begin
        r_pos_x  <= pos_x;
        r_pos_y  <= pos_y;
        r_width  <= width;
        r_height <= height;
        r_col    <= '0;
        r_row    <= '0;
        r_index  <= '0;
      end
      if (w_advance) begin
        r_index <= r_index + 17'd1;
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= r_row + 9'd1;
        end else begin
          r_col <= r_col + 9'd1;
        end
      end
      if (w_load_fb) begin
        r_fb_addr <= w_fb_addr;
        r_fb_data <= color;
      end
    end
  end

  // Reset kills an in-flight write and any done pulse in the same cycle it is raised.
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE) && !reset;
  assign fb_we   = (r_state == ST_WRITE) && !reset;
  assign pixel   = r_index;
  assign fb_addr = r_fb_addr;
  assign fb_data = r_fb_data;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed test-plan blits plus randomized
// blits compared against a per-pixel reference model of the copy rules.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  pos_x;
  logic [7:0]  pos_y;
  logic        busy;
  logic        done;
  logic [16:0] pixel;
  logic [8:0]  width;
  logic [8:0]  height;
  logic [15:0] color;
  logic [16:0] fb_addr;
  logic [15:0] fb_data;
  logic        fb_we;
  logic        fb_ready;

  logic [15:0] rom [0:63];

  typedef struct {
    logic [16:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t got_q[$];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign color = (pixel < 17'd64) ? rom[pixel[5:0]] : 16'h0000;

  sprite_blitter #(
    .FB_WIDTH (320),
    .FB_HEIGHT(240),
    .KEY_COLOR(16'hFFFF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pos_x   (pos_x),
    .pos_y   (pos_y),
    .busy    (busy),
    .done    (done),
    .pixel   (pixel),
    .width   (width),
    .height  (height),
    .color   (color),
    .fb_addr (fb_addr),
    .fb_data (fb_data),
    .fb_we   (fb_we),
    .fb_ready(fb_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load_test_rom();
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1234; rom[1] = 16'hFFFF; rom[2] = 16'h0001;
    rom[3] = 16'h0002; rom[4] = 16'h0003; rom[5] = 16'hFFFF;
  endtask

  // Reference: visit every sprite pixel, keep the visible non-key ones in order.
  task automatic model(input int px, input int py, input int w, input int h, output int skipped);
    exp_q.delete();
    skipped = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int x;
        int y;
        wr_t e;
        x = px + c;
        y = py + r;
        if (rom[r * w + c] != 16'hFFFF && x < 320 && y < 240) begin
          e.a = 17'(y * 320 + x);
          e.d = rom[r * w + c];
          exp_q.push_back(e);
        end else begin
          skipped++;
        end
      end
    end
  endtask

  // mode 0: ready always high; 1: stall first write stall_n cycles; 2: random ready + ROM size inputs scrambled.
  task automatic run_blit(input int px, input int py, input int w, input int h,
                          input int mode, input int stall_n, input string tag);
    int skipped;
    int busy_cyc;
    int stalls;
    int dones;
    int cyc;
    int stall_left;
    bit hold_valid;
    logic [16:0] hold_a;
    logic [15:0] hold_d;
    wr_t g;
    model(px, py, w, h, skipped);
    got_q.delete();
    pos_x  = 9'(px);
    pos_y  = 8'(py);
    width  = 9'(w);
    height = 9'(h);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (mode == 2) begin
      width  = 9'($urandom);
      height = 9'($urandom);
    end
    busy_cyc = 0; stalls = 0; dones = 0; cyc = 0;
    stall_left = stall_n; hold_valid = 1'b0; hold_a = '0; hold_d = '0;
    while (busy && cyc < 2000) begin
      busy_cyc++;
      if (mode == 1) begin
        if (fb_we && stall_left > 0) begin
          fb_ready = 1'b0;
          stall_left--;
        end else begin
          fb_ready = 1'b1;
        end
      end else if (mode == 2) begin
        fb_ready = ($urandom_range(0, 2) != 0);
      end else begin
        fb_ready = 1'b1;
      end
      if (hold_valid) begin
        chk({tag, " hold_we"}, 32'(fb_we), 32'd1);
        chk({tag, " hold_addr"}, 32'(fb_addr), 32'(hold_a));
        chk({tag, " hold_data"}, 32'(fb_data), 32'(hold_d));
      end
      hold_valid = fb_we && !fb_ready;
      if (hold_valid) begin
        hold_a = fb_addr;
        hold_d = fb_data;
        stalls++;
      end
      if (fb_we && fb_ready) begin
        g.a = fb_addr;
        g.d = fb_data;
        got_q.push_back(g);
      end
      if (done) dones++;
      @(posedge clk); #1;
      cyc++;
    end
    fb_ready = 1'b1;
    chk({tag, " timeout"}, 32'(cyc < 2000), 32'd1);
    chk({tag, " write_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s wr%0d_addr", tag, i), 32'(got_q[i].a), 32'(exp_q[i].a));
      chk($sformatf("%s wr%0d_data", tag, i), 32'(got_q[i].d), 32'(exp_q[i].d));
    end
    chk({tag, " done_pulses"}, 32'(dones), 32'd1);
    chk({tag, " cycles"}, 32'(busy_cyc), 32'(2 + skipped + 2 * exp_q.size() + stalls));
    if (mode == 1) chk({tag, " stalls"}, 32'(stalls), 32'(stall_n));
    $display("blit %s: pos=(%0d,%0d) size=%0dx%0d writes=%0d busy_cycles=%0d stalls=%0d",
             tag, px, py, w, h, got_q.size(), busy_cyc, stalls);
  endtask

  task automatic wait_we(input int limit, output bit ok);
    int n;
    n = 0;
    while (!fb_we && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    ok = fb_we;
  endtask

  initial begin
    bit ok;
    reset = 1'b1; start = 1'b0; pos_x = '0; pos_y = '0;
    width = '0; height = '0; fb_ready = 1'b1;
    load_test_rom();
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset fb_we", 32'(fb_we), 32'd0);
    chk("reset pixel", 32'(pixel), 32'd0);
    chk("reset fb_addr", 32'(fb_addr), 32'd0);
    chk("reset fb_data", 32'(fb_data), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_blit(10, 5, 3, 2, 0, 0, "basic");
    run_blit(318, 5, 3, 2, 0, 0, "clip_x");
    run_blit(10, 5, 3, 2, 1, 5, "stall5");
    run_blit(10, 5, 0, 2, 0, 0, "width0");

    // Second start during a blit is ignored; reset lands in the second WRITE.
    pos_x = 9'd10; pos_y = 8'd5; width = 9'd3; height = 9'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_we(20, ok);
    chk("restart first_we", 32'(ok), 32'd1);
    chk("restart first_addr", 32'(fb_addr), 32'd1610);
    start = 1'b1; pos_x = 9'd0; pos_y = 8'd0;
    @(posedge clk); #1;
    wait_we(20, ok);
    start = 1'b0;
    chk("restart second_we", 32'(ok), 32'd1);
    chk("restart second_addr", 32'(fb_addr), 32'd1612);
    reset = 1'b1;
    #1;
    chk("restart we_drop", 32'(fb_we), 32'd0);
    chk("restart no_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("restart busy", 32'(busy), 32'd0);
    chk("restart fb_we", 32'(fb_we), 32'd0);
    chk("restart done", 32'(done), 32'd0);
    chk("restart pixel", 32'(pixel), 32'd0);
    @(posedge clk); #1;
    chk("restart idle_done", 32'(done), 32'd0);
    run_blit(0, 0, 3, 2, 0, 0, "from_origin");
    chk("from_origin first_addr", 32'(got_q.size() > 0 ? got_q[0].a : 17'h1FFFF), 32'd0);

    for (int t = 0; t < 25; t++) begin
      int px;
      int py;
      for (int i = 0; i < 64; i++)
        rom[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      px = ($urandom_range(0, 1) == 1) ? $urandom_range(300, 511) : $urandom_range(0, 319);
      py = ($urandom_range(0, 1) == 1) ? $urandom_range(230, 255) : $urandom_range(0, 239);
      run_blit(px, py, $urandom_range(0, 8), $urandom_range(0, 6), 2, 0, $sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
